// File: rtl/vram_arbiter.sv
// Purpose : arbitrates one single-port tile RAM between display fetch (priority) and CPU access.
// Latency : RAM port registered one cycle after grant; read data returned two cycles after grant.
// Backpres: req/gnt handshake; display wins unless the CPU has waited MAX_WAIT cycles.
module vram_arbiter #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    output logic [DATA_W-1:0] disp_rdata,
    output logic              disp_rvalid,
    output logic              disp_miss,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,

    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    // Starvation threshold in the counter's own width (legal range 1..15).
    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    // Owner tag carried alongside each in-flight read.
    typedef enum logic {
        OWN_DISP = 1'b0,
        OWN_CPU  = 1'b1
    } owner_e;

    // Starvation counter.
    logic [3:0]        wait_q;
    logic [3:0]        wait_d;

    // Arbitration results for the current cycle.
    logic              force_c;
    logic              disp_gnt_c;
    logic              cpu_gnt_c;
    logic              disp_miss_c;

    // Accepted transfer, selected from the winning requester.
    logic              xfer_vld_c;
    logic [ADDR_W-1:0] xfer_addr_c;
    logic              xfer_we_c;
    logic              rd_vld_c;
    owner_e            rd_own_c;

    // Registered RAM port.
    logic [ADDR_W-1:0] ram_addr_q;
    logic              ram_we_q;
    logic [DATA_W-1:0] ram_wdata_q;

    // Read pipeline stage 1: a read is on the RAM port this cycle.
    logic              rd1_vld_q;
    owner_e            rd1_own_q;

    // Read pipeline stage 2: returned data per owner.
    logic              disp_rvalid_q;
    logic [DATA_W-1:0] disp_rdata_q;
    logic              cpu_rvalid_q;
    logic [DATA_W-1:0] cpu_rdata_q;

    // Grant decision: display has priority except when the CPU has hit its wait limit.
    // Force is qualified by cpu_req so a vanished CPU request never costs the display a slot.
    // Grants are gated by reset so nothing is offered while the block is held in reset.
    always_comb begin
        force_c     = (wait_q == MAX_WAIT_C) && cpu_req;
        disp_gnt_c  = reset && disp_req && !force_c;
        cpu_gnt_c   = reset && cpu_req && (!disp_req || force_c);
        disp_miss_c = reset && disp_req && force_c;
    end

    // Next wait count: grows while the CPU is held off, otherwise restarts from zero.
    always_comb begin
        wait_d = 4'd0;
        if (cpu_req && !cpu_gnt_c) begin
            wait_d = wait_q + 4'd1;
        end
    end

    // Select the transfer that will be launched onto the RAM port at the next edge.
    always_comb begin
        xfer_vld_c  = disp_gnt_c || cpu_gnt_c;
        xfer_addr_c = cpu_gnt_c ? cpu_addr : disp_addr;
        xfer_we_c   = cpu_gnt_c && cpu_we;
        rd_vld_c    = xfer_vld_c && !xfer_we_c;
        rd_own_c    = cpu_gnt_c ? OWN_CPU : OWN_DISP;
    end

    // Wait counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_q <= 4'd0;
        end else begin
            wait_q <= wait_d;
        end
    end

    // RAM port: launch the accepted transfer; address and write data hold when idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
        end else begin
            ram_we_q <= xfer_we_c;
            if (xfer_vld_c) begin
                ram_addr_q <= xfer_addr_c;
            end
            if (xfer_we_c) begin
                ram_wdata_q <= cpu_wdata;
            end
        end
    end

    // Read pipeline stage 1: remember whether a read is on the port and who owns it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd1_vld_q <= 1'b0;
            rd1_own_q <= OWN_DISP;
        end else begin
            rd1_vld_q <= rd_vld_c;
            rd1_own_q <= rd_own_c;
        end
    end

    // Read pipeline stage 2: capture RAM data into the owner's return register for one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            disp_rvalid_q <= 1'b0;
            disp_rdata_q  <= '0;
            cpu_rvalid_q  <= 1'b0;
            cpu_rdata_q   <= '0;
        end else begin
            disp_rvalid_q <= rd1_vld_q && (rd1_own_q == OWN_DISP);
            cpu_rvalid_q  <= rd1_vld_q && (rd1_own_q == OWN_CPU);
            if (rd1_vld_q && (rd1_own_q == OWN_DISP)) begin
                disp_rdata_q <= ram_rdata;
            end
            if (rd1_vld_q && (rd1_own_q == OWN_CPU)) begin
                cpu_rdata_q <= ram_rdata;
            end
        end
    end

    assign disp_gnt    = disp_gnt_c;
    assign cpu_gnt     = cpu_gnt_c;
    assign disp_miss   = disp_miss_c;
    assign ram_addr    = ram_addr_q;
    assign ram_we      = ram_we_q;
    assign ram_wdata   = ram_wdata_q;
    assign disp_rvalid = disp_rvalid_q;
    assign disp_rdata  = disp_rdata_q;
    assign cpu_rvalid  = cpu_rvalid_q;
    assign cpu_rdata   = cpu_rdata_q;

endmodule
